// File: rtl/arf192b080e1r1w0cbbehbaa4acw_wr_en_ctl.sv
// arf192b080e1r1w0cbbehbaa4acw_wr_en_ctl: 192-row write-enable controller, 2-deep queue, registered one-hot bank/row issue.
// Optional drop counter enabled by ARF192B080E1R1W0CBBEHBAA4ACW_WR_DROP_CNT_EN.
module arf192b080e1r1w0cbbehbaa4acw_wr_en_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [7:0]  in_addr,
  input  logic [79:0] in_data,
  input  logic        fd,
  input  logic        err_clr,
  output logic [11:0] bank_en,
  output logic [15:0] row_sel,
  output logic [79:0] wr_data,
  output logic        wr_err
`ifdef ARF192B080E1R1W0CBBEHBAA4ACW_WR_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);
  logic [87:0] r_q0, r_q1;
  logic [1:0]  r_cnt;
  logic [11:0] r_bank;
  logic [15:0] r_row;
  logic [79:0] r_data;
  logic        r_err;
  logic        w_acc, w_ok, w_bad, w_pop, w_byp, w_push, w_go;
  logic [87:0] w_new, w_iss, w_e0;
  logic [1:0]  w_lvl;
  assign in_rdy = ~rst & (r_cnt != 2'd2);
  assign w_acc  = in_vld & in_rdy;
  assign w_ok   = in_addr < 8'd192;
  assign w_bad  = w_acc & ~w_ok;
  assign w_new  = {in_addr, in_data};
  // queue head has priority; an empty queue lets a fresh legal write bypass straight to issue
  assign w_pop  = ~fd & (r_cnt != 2'd0);
  assign w_byp  = ~fd & (r_cnt == 2'd0) & w_acc & w_ok;
  assign w_push = w_acc & w_ok & ~w_byp;
  assign w_go   = w_pop | w_byp;
  assign w_iss  = w_pop ? r_q0 : w_new;
  assign w_e0   = w_pop ? r_q1 : r_q0;
  assign w_lvl  = r_cnt - {1'b0, w_pop};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_q0   <= '0;
      r_q1   <= '0;
      r_cnt  <= '0;
      r_bank <= '0;
      r_row  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      r_q0   <= (w_push && w_lvl == 2'd0) ? w_new : w_e0;
      r_q1   <= (w_push && w_lvl == 2'd1) ? w_new : r_q1;
      r_cnt  <= w_lvl + {1'b0, w_push};
      r_bank <= w_go ? 12'(1) << w_iss[87:84] : '0;
      r_row  <= w_go ? 16'(1) << w_iss[83:80] : '0;
      r_data <= w_go ? w_iss[79:0] : r_data;
      r_err  <= w_bad | (r_err & ~err_clr);
    end
  assign bank_en = r_bank;
  assign row_sel = r_row;
  assign wr_data = r_data;
  assign wr_err  = r_err;
`ifdef ARF192B080E1R1W0CBBEHBAA4ACW_WR_DROP_CNT_EN
  logic [7:0] r_drop, w_dbase;
  // clear applies first so a same-cycle increment lands on 1
  assign w_dbase = err_clr ? 8'd0 : r_drop;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_drop <= '0;
    else r_drop <= w_bad ? ((w_dbase == 8'hff) ? 8'hff : w_dbase + 8'd1) : w_dbase;
  assign drop_cnt = r_drop;
`endif
endmodule
